// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, raster phase enum and axis helpers
package vga_timing_pkg;

    // 640x480@60 defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    // Phase owning position pos. A zero-length interval can never match,
    // so entering through this function skips empty porches in one step.
    function automatic phase_t phase_at(input int unsigned pos, input int unsigned act,
                                        input int unsigned fp, input int unsigned sync);
        phase_t ph;
        if (pos < act)
            ph = PH_ACTIVE;
        else if (pos < act + fp)
            ph = PH_FRONT;
        else if (pos < act + fp + sync)
            ph = PH_SYNC;
        else
            ph = PH_BACK;
        return ph;
    endfunction

    // First position after the given phase.
    function automatic int unsigned phase_end(input phase_t ph, input int unsigned act,
                                              input int unsigned fp, input int unsigned sync,
                                              input int unsigned bp);
        int unsigned e;
        case (ph)
            PH_ACTIVE: e = act;
            PH_FRONT:  e = act + fp;
            PH_SYNC:   e = act + fp + sync;
            default:   e = act + fp + sync + bp;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - resettable shift register delaying a small bus by DEPTH clk
// Ports:
//   clk    in   1      clock (shifts every cycle, no enable)
//   reset  in   1      synchronous active-high, clears every stage
//   d      in   WIDTH  input bus
//   q      out  WIDTH  d delayed by DEPTH cycles (DEPTH=0: combinational pass-through)
module sync_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_reset;
            assign unused_clk_reset = clk ^ reset;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++)
                        stages[i] <= '0;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++)
                        stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: position, active video, syncs and line/frame strobes
// Ports:
//   clk        in   1       system clock
//   reset      in   1       synchronous active-high reset
//   en         in   1       pixel-clock enable; raster advances one pixel per enabled clk
//   x          out  X_BITS  horizontal position 0..H_TOTAL-1
//   y          out  Y_BITS  vertical position 0..V_TOTAL-1
//   active     out  1       x<H_ACTIVE and y<V_ACTIVE
//   hsync      out  1       active-high hsync, delayed SYNC_DELAY clk
//   vsync      out  1       active-high vsync, delayed SYNC_DELAY clk
//   new_line   out  1       one-clk strobe alongside x wrapping to 0
//   new_frame  out  1       one-clk strobe alongside (x,y) wrapping to (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int          X_BITS     = 10,
    parameter int          Y_BITS     = 10,
    parameter int          SYNC_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              active,
    output logic              hsync,
    output logic              vsync,
    output logic              new_line,
    output logic              new_frame
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_TOTAL - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_TOTAL - 1);

    generate
        if (longint'(H_TOTAL) > (longint'(1) << X_BITS)) begin : g_bad_x_bits
            $error("vga_timing_gen: X_BITS too narrow for H_TOTAL");
        end
        if (longint'(V_TOTAL) > (longint'(1) << Y_BITS)) begin : g_bad_y_bits
            $error("vga_timing_gen: Y_BITS too narrow for V_TOTAL");
        end
    endgenerate

    logic [X_BITS-1:0] x_next;
    logic [Y_BITS-1:0] y_next;
    logic              x_wrap;
    logic              y_wrap;
    phase_t            h_state, h_next;
    phase_t            v_state, v_next;
    logic              hsync_raw;
    logic              vsync_raw;
    logic [1:0]        sync_q;

    // Next position and both axis phase FSMs. A phase is left only when the
    // next position reaches its end (or the axis wraps); the successor is
    // looked up from that position so empty porches are stepped over.
    always_comb begin
        x_wrap = (x == X_LAST);
        y_wrap = (y == Y_LAST);
        x_next = x;
        y_next = y;
        h_next = h_state;
        v_next = v_state;
        if (en) begin
            x_next = x_wrap ? '0 : x + 1'b1;
            if (x_wrap)
                y_next = y_wrap ? '0 : y + 1'b1;

            if (x_wrap || 32'(x_next) == phase_end(h_state, H_ACTIVE, H_FP, H_SYNC, H_BP))
                h_next = phase_at(32'(x_next), H_ACTIVE, H_FP, H_SYNC);

            // Vertical phase only moves on a line wrap, so vsync spans whole lines.
            if (x_wrap && (y_wrap ||
                           32'(y_next) == phase_end(v_state, V_ACTIVE, V_FP, V_SYNC, V_BP)))
                v_next = phase_at(32'(y_next), V_ACTIVE, V_FP, V_SYNC);
        end
    end

    // Flags are decoded from the next phase so they line up with the x/y
    // registered in the same edge. They hold while en=0, which also keeps the
    // post-reset zeros until the raster first advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            h_state   <= PH_ACTIVE;
            v_state   <= PH_ACTIVE;
            active    <= 1'b0;
            hsync_raw <= 1'b0;
            vsync_raw <= 1'b0;
            new_line  <= 1'b0;
            new_frame <= 1'b0;
        end else begin
            x         <= x_next;
            y         <= y_next;
            h_state   <= h_next;
            v_state   <= v_next;
            new_line  <= en && x_wrap;
            new_frame <= en && x_wrap && y_wrap;
            if (en) begin
                active    <= (h_next == PH_ACTIVE) && (v_next == PH_ACTIVE);
                hsync_raw <= (h_next == PH_SYNC);
                vsync_raw <= (v_next == PH_SYNC);
            end
        end
    end

    sync_delay_line #(
        .WIDTH (2),
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .d     ({hsync_raw, vsync_raw}),
        .q     (sync_q)
    );

    assign hsync = sync_q[1];
    assign vsync = sync_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a raster arithmetic model
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    always #5 clk = ~clk;

    // default (d_), SYNC_DELAY=3 (g_), medium (m_), tiny (s_), tiny zero porch (z_)
    logic [9:0] d_x, d_y, g_x, g_y, m_x, m_y, s_x, s_y, z_x, z_y;
    logic d_active, d_hsync, d_vsync, d_nl, d_nf;
    logic g_active, g_hsync, g_vsync, g_nl, g_nf;
    logic m_active, m_hsync, m_vsync, m_nl, m_nf;
    logic s_active, s_hsync, s_vsync, s_nl, s_nf;
    logic z_active, z_hsync, z_vsync, z_nl, z_nf;

    vga_timing_gen u_def (.clk(clk), .reset(reset), .en(en), .x(d_x), .y(d_y), .active(d_active),
        .hsync(d_hsync), .vsync(d_vsync), .new_line(d_nl), .new_frame(d_nf));
    vga_timing_gen #(.SYNC_DELAY(3)) u_dly (.clk(clk), .reset(reset), .en(en), .x(g_x), .y(g_y),
        .active(g_active), .hsync(g_hsync), .vsync(g_vsync), .new_line(g_nl), .new_frame(g_nf));
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(12), .V_FP(2),
        .V_SYNC(2), .V_BP(3)) u_med (.clk(clk), .reset(reset), .en(en), .x(m_x), .y(m_y),
        .active(m_active), .hsync(m_hsync), .vsync(m_vsync), .new_line(m_nl), .new_frame(m_nf));
    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1),
        .V_SYNC(1), .V_BP(1)) u_tiny (.clk(clk), .reset(reset), .en(en), .x(s_x), .y(s_y),
        .active(s_active), .hsync(s_hsync), .vsync(s_vsync), .new_line(s_nl), .new_frame(s_nf));
    vga_timing_gen #(.H_ACTIVE(4), .H_FP(0), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(0),
        .V_SYNC(1), .V_BP(1)) u_zfp (.clk(clk), .reset(reset), .en(en), .x(z_x), .y(z_y),
        .active(z_active), .hsync(z_hsync), .vsync(z_vsync), .new_line(z_nl), .new_frame(z_nf));

    logic [24:0] obs_def, obs_med, obs_tiny, obs_zfp;
    assign obs_def  = {d_x, d_y, d_active, d_hsync, d_vsync, d_nl, d_nf};
    assign obs_med  = {m_x, m_y, m_active, m_hsync, m_vsync, m_nl, m_nf};
    assign obs_tiny = {s_x, s_y, s_active, s_hsync, s_vsync, s_nl, s_nf};
    assign obs_zfp  = {z_x, z_y, z_active, z_hsync, z_vsync, z_nl, z_nf};

    // Model: ticks = enabled edges since reset; everything follows from it.
    longint ticks = 0;
    bit     last_en = 1'b0;
    bit [3:0] uh_h = '0, uh_v = '0;
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic logic [24:0] exp_vec(input int ha, input int hfp, input int hs, input int hbp,
                                            input int va, input int vfp, input int vs, input int vbp);
        longint ht = longint'(ha + hfp + hs + hbp);
        longint vt = longint'(va + vfp + vs + vbp);
        longint px = ticks % ht;
        longint py = (ticks / ht) % vt;
        logic a = 1'b0, h = 1'b0, v = 1'b0, nl, nf;
        if (ticks != 0) begin
            a = (px < ha) && (py < va);
            h = (px >= ha + hfp) && (px < ha + hfp + hs);
            v = (py >= va + vfp) && (py < va + vfp + vs);
        end
        nl = last_en && (ticks != 0) && (px == 0);
        nf = nl && (py == 0);
        return {10'(px), 10'(py), a, h, v, nl, nf};
    endfunction

    function automatic logic [24:0] exp_def();  return exp_vec(640, 16, 96, 48, 480, 10, 2, 33); endfunction
    function automatic logic [24:0] exp_med();  return exp_vec(16, 2, 3, 2, 12, 2, 2, 3);        endfunction
    function automatic logic [24:0] exp_tiny(); return exp_vec(4, 1, 1, 1, 2, 1, 1, 1);          endfunction
    function automatic logic [24:0] exp_zfp();  return exp_vec(4, 0, 1, 1, 2, 0, 1, 1);          endfunction

    task automatic step(input bit e);
        logic [24:0] u;
        en = e;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            ticks = 0; last_en = 1'b0; uh_h = '0; uh_v = '0;
        end else begin
            ticks += longint'(e);
            last_en = e;
            u = exp_def();
            uh_h = {uh_h[2:0], u[3]};
            uh_v = {uh_v[2:0], u[2]};
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'($urandom_range(0, 1)));
        step(1'($urandom_range(0, 1)));
        n_cmp += 5;
        if (obs_def !== '0) begin n_bad++; $display("FAIL reset_def got=%h exp=0", obs_def); end
        if (obs_med !== '0) begin n_bad++; $display("FAIL reset_med got=%h exp=0", obs_med); end
        if (obs_tiny !== '0) begin n_bad++; $display("FAIL reset_tiny got=%h exp=0", obs_tiny); end
        if (obs_zfp !== '0) begin n_bad++; $display("FAIL reset_zfp got=%h exp=0", obs_zfp); end
        if ({g_x, g_y, g_active, g_hsync, g_vsync, g_nl, g_nf} !== '0) begin
            n_bad++; $display("FAIL reset_dly got nonzero outputs exp=0");
        end
        reset = 1'b0;
    endtask

    task automatic test_line_timing();
        bit prev_h = 0, prev_nl = 0;
        int hcnt = 0, last_nl = -1;
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            step(1'b1);
            n_cmp++;
            if (obs_def !== exp_def()) begin
                n_bad++; $display("FAIL line_cycle cyc=%0d got=%h exp=%h", cyc, obs_def, exp_def());
            end
            if (d_hsync && !prev_h) begin
                n_cmp++;
                if (d_x !== 10'd656) begin n_bad++; $display("FAIL hsync_rise_x got=%0d exp=656", d_x); end
            end
            if (d_hsync) hcnt++;
            if (!d_hsync && prev_h) begin
                n_cmp++;
                if (hcnt != 96) begin n_bad++; $display("FAIL hsync_width got=%0d exp=96", hcnt); end
                hcnt = 0;
            end
            if (d_nl) begin
                if (last_nl >= 0) begin
                    n_cmp++;
                    if (cyc - last_nl != 800) begin
                        n_bad++; $display("FAIL line_period got=%0d exp=800", cyc - last_nl);
                    end
                end
                last_nl = cyc;
            end
            if (d_nl && prev_nl) begin n_bad++; $display("FAIL new_line_width got=2+ exp=1"); end
            prev_h = d_hsync; prev_nl = d_nl;
        end
    endtask

    task automatic test_en_toggle();
        bit prev_nl = 0, prev_nf = 0;
        int last_nl = -1;
        logic [9:0] prev_x;
        do_reset();
        prev_x = d_x;
        for (int i = 0; i < 3400; i++) begin
            step(1'(i % 2 == 0));
            n_cmp++;
            if (obs_def !== exp_def()) begin
                n_bad++; $display("FAIL toggle_cycle cyc=%0d got=%h exp=%h", cyc, obs_def, exp_def());
            end
            if (!last_en) begin
                n_cmp++;
                if (d_x !== prev_x) begin n_bad++; $display("FAIL x_hold got=%0d exp=%0d", d_x, prev_x); end
            end
            if (d_nl) begin
                if (last_nl >= 0) begin
                    n_cmp++;
                    if (cyc - last_nl != 1600) begin
                        n_bad++; $display("FAIL toggle_line_period got=%0d exp=1600", cyc - last_nl);
                    end
                end
                last_nl = cyc;
            end
            if ((d_nl && prev_nl) || (d_nf && prev_nf)) begin
                n_bad++; $display("FAIL toggle_strobe_width got=2+ exp=1");
            end
            prev_nl = d_nl; prev_nf = d_nf; prev_x = d_x;
        end
    endtask

    task automatic test_frames();
        bit prev_vs = 0;
        longint last_nf_ticks = -1;
        int frames = 0;
        do_reset();
        for (int i = 0; i < 2400; i++) begin
            step(1'($urandom_range(0, 3) != 0));
            n_cmp++;
            if (obs_med !== exp_med()) begin
                n_bad++; $display("FAIL frame_cycle cyc=%0d got=%h exp=%h", cyc, obs_med, exp_med());
            end
            if (m_vs_changed(prev_vs) && !m_nl) begin
                n_bad++; $display("FAIL vsync_edge_not_on_line got nl=0 exp=1");
            end
            if (m_nf) begin
                frames++;
                n_cmp++;
                if ({m_x, m_y} !== 20'd0) begin
                    n_bad++; $display("FAIL frame_pos got=(%0d,%0d) exp=(0,0)", m_x, m_y);
                end
                if (last_nf_ticks >= 0) begin
                    n_cmp++;
                    if (ticks - last_nf_ticks != 437) begin
                        n_bad++; $display("FAIL frame_period got=%0d exp=437", ticks - last_nf_ticks);
                    end
                end
                last_nf_ticks = ticks;
            end
            prev_vs = m_vsync;
        end
        n_cmp++;
        if (frames < 2) begin n_bad++; $display("FAIL frame_count got=%0d exp>=2", frames); end
    endtask

    function automatic bit m_vs_changed(input bit prev);
        return m_vsync != prev;
    endfunction

    task automatic test_reset_mid();
        int guard = 0;
        do_reset();
        for (int i = 0; i < 1900; i++) step(1'b1);
        n_cmp++;
        if (d_x !== 10'd300 || d_y !== 10'd2) begin
            n_bad++; $display("FAIL mid_position got=(%0d,%0d) exp=(300,2)", d_x, d_y);
        end
        do_reset();
        n_cmp += 2;
        if (obs_def !== '0) begin n_bad++; $display("FAIL mid_reset_def got=%h exp=0", obs_def); end
        if (obs_med !== '0) begin n_bad++; $display("FAIL mid_reset_med got=%h exp=0", obs_med); end
        while (!m_nf && guard < 5000) begin
            step(1'($urandom_range(0, 1)));
            guard++;
        end
        n_cmp++;
        if (!m_nf) begin n_bad++; $display("FAIL first_frame_timeout got=none exp=new_frame"); end
        else if (ticks != 437) begin n_bad++; $display("FAIL first_frame_ticks got=%0d exp=437", ticks); end
    endtask

    task automatic test_sync_delay();
        logic [24:0] e;
        int rise_ref = -1, rise_dly = -1;
        bit prev_ref = 0, prev_dly = 0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(i < 1700 ? 1'b1 : 1'($urandom_range(0, 1)));
            e = exp_def();
            n_cmp += 2;
            if ({g_x, g_y, g_active, g_nl, g_nf} !== {e[24:4], e[1:0]}) begin
                n_bad++; $display("FAIL dly_pos cyc=%0d got=%h exp=%h", cyc,
                                  {g_x, g_y, g_active, g_nl, g_nf}, {e[24:4], e[1:0]});
            end
            if ({g_hsync, g_vsync} !== {uh_h[3], uh_v[3]}) begin
                n_bad++; $display("FAIL dly_sync cyc=%0d got=%b exp=%b", cyc, {g_hsync, g_vsync},
                                  {uh_h[3], uh_v[3]});
            end
            if (d_hsync && !prev_ref && rise_ref < 0) rise_ref = cyc;
            if (g_hsync && !prev_dly && rise_dly < 0) rise_dly = cyc;
            prev_ref = d_hsync; prev_dly = g_hsync;
        end
        n_cmp++;
        if (rise_ref < 0 || rise_dly - rise_ref != 3) begin
            n_bad++; $display("FAIL dly_rise_offset got=%0d exp=3", rise_dly - rise_ref);
        end
    endtask

    task automatic test_tiny();
        int guard = 0;
        do_reset();
        while (ticks < 3 * 35 + 1 && guard < 1000) begin
            step(1'($urandom_range(0, 4) != 0));
            guard++;
            n_cmp += 2;
            if (obs_tiny !== exp_tiny()) begin
                n_bad++; $display("FAIL tiny_cycle cyc=%0d got=%h exp=%h", cyc, obs_tiny, exp_tiny());
            end
            if (obs_zfp !== exp_zfp()) begin
                n_bad++; $display("FAIL zfp_cycle cyc=%0d got=%h exp=%h", cyc, obs_zfp, exp_zfp());
            end
        end
        n_cmp++;
        if (ticks < 3 * 35 + 1) begin n_bad++; $display("FAIL tiny_timeout got=%0d exp=106", ticks); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            step(1'($urandom_range(0, 2) != 0));
            n_cmp += 4;
            if (obs_def !== exp_def()) begin
                n_bad++; $display("FAIL b2b_def cyc=%0d got=%h exp=%h", cyc, obs_def, exp_def());
            end
            if (obs_med !== exp_med()) begin
                n_bad++; $display("FAIL b2b_med cyc=%0d got=%h exp=%h", cyc, obs_med, exp_med());
            end
            if (obs_tiny !== exp_tiny()) begin
                n_bad++; $display("FAIL b2b_tiny cyc=%0d got=%h exp=%h", cyc, obs_tiny, exp_tiny());
            end
            if (obs_zfp !== exp_zfp()) begin
                n_bad++; $display("FAIL b2b_zfp cyc=%0d got=%h exp=%h", cyc, obs_zfp, exp_zfp());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_en_toggle();
        test_frames();
        test_reset_mid();
        test_sync_delay();
        test_tiny();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
